// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: store-width encodings, drain FSM states, FIFO entry layout.
// No logic; latency and backpressure are not applicable.
package store_buffer_pkg;

  localparam logic [1:0] SEL_WORD = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_BYTE = 2'b10;
  localparam logic [1:0] SEL_INV  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

endpackage

// File: rtl/store_buffer_be_decode.sv
// Byte-enable decode from store width and low address bits; an all-zero result marks a misaligned/invalid store.
// Latency: combinational; backpressure: none.
module be_decode
  import store_buffer_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [1:0] lo,
  output logic [3:0] be
);

  always_comb begin
    be = 4'b0000;
    case (sel)
      SEL_WORD: be = 4'b1111;
      SEL_HALF: begin
        if (lo == 2'd0)      be = 4'b0011;
        else if (lo == 2'd2) be = 4'b1100;
        else                 be = 4'b0000;
      end
      SEL_BYTE: be = 4'b0001 << lo;
      default:  be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO drained to data memory by a two-state req/ack FSM, with a load-word hazard compare.
// Latency: a store into an empty buffer raises mem_req two cycles later; backpressure: st_ready drops while full.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [1:0]  st_sel,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        empty,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t            ent_q [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  state_e            state;
  state_e            state_nxt;
  logic [3:0]        st_be;
  logic              push;
  logic              drop;
  logic              pop;
  entry_t            head;
  logic [DEPTH-1:0]  ent_vld;
  logic              hit;
  logic              unused_ld_lo;

  be_decode u_be_decode (
    .sel (st_sel),
    .lo  (st_addr[1:0]),
    .be  (st_be)
  );

  // Ready comes from the registered count only, so a same-cycle pop never frees a slot while full.
  assign st_ready = (count != CW'(DEPTH));
  assign push     = st_valid && st_ready && (st_be != 4'b0000);
  assign drop     = st_valid && st_ready && (st_be == 4'b0000);
  assign pop      = (state == REQ) && mem_ack;
  assign head     = ent_q[rd_ptr];
  assign empty    = (count == '0) && (state == IDLE);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
      state        <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count        <= count_nxt;
      misalign_err <= drop;
      state        <= state_nxt;
    end
  end

  // Entry storage carries no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) ent_q[wr_ptr] <= '{addr: st_addr[31:2], wdata: st_wdata, be: st_be};
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'b0000;
    case (state)
      IDLE: begin
        if (count != '0) state_nxt = REQ;
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_addr  = {head.addr, 2'b00};
        mem_wdata = head.wdata;
        mem_be    = head.be;
        if (pop) state_nxt = (count_nxt != '0) ? REQ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // An entry is live when its distance from the head is below count; the head being drained counts too.
  always_comb begin
    ent_vld = '0;
    hit     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i] = ({1'b0, AW'(AW'(i) - rd_ptr)} < count);
      if (ent_vld[i] && (ent_q[i].addr == ld_addr[31:2])) hit = 1'b1;
    end
  end

  assign ld_stall     = ld_valid && hit;
  assign unused_ld_lo = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected writes queued at store time, compared on each memory handshake.
module tb_store_buffer;
  import store_buffer_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [1:0]  st_sel;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        empty;
  logic        misalign_err;

  exp_t sb[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_wdata     (st_wdata),
    .st_sel       (st_sel),
    .st_ready     (st_ready),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_stall     (ld_stall),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ack      (mem_ack),
    .empty        (empty),
    .misalign_err (misalign_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_be(input logic [1:0] sel, input logic [1:0] lo);
    if (sel == 2'b00) return 4'hF;
    if (sel == 2'b01) return (lo == 2'd0) ? 4'h3 : ((lo == 2'd2) ? 4'hC : 4'h0);
    if (sel == 2'b10) return 4'b0001 << lo;
    return 4'h0;
  endfunction

  // Drives one store for a cycle; exp_rdy is what the bench expects st_ready to be.
  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s, input logic exp_rdy);
    logic [3:0] b;
    b        = model_be(s, a[1:0]);
    st_valid = 1'b1;
    st_addr  = a;
    st_wdata = d;
    st_sel   = s;
    #1;
    check("put_rdy", st_ready, exp_rdy);
    if (exp_rdy && b != 4'h0) sb.push_back('{addr: {a[31:2], 2'b00}, wdata: d, be: b});
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n       = 0;
    mem_ack = 1'b1;
    while (!empty && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", empty, 1'b1);
    mem_ack = 1'b0;
  endtask

  // Handshake monitor, sampled mid-low-phase after stimulus has settled.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset && mem_req && mem_ack) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.wdata);
        check("wr_be", mem_be, e.be);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    exp_t        e;

    reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_sel = SEL_WORD;
    ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1; ld_valid = 1'b1;
    #1;
    check("rst_req", mem_req, 1'b0);
    check("rst_rdy", st_ready, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_stall", ld_stall, 1'b0);
    check("rst_mis", misalign_err, 1'b0);
    ld_valid = 1'b0;

    // Word store into an empty buffer, acked in the first request cycle.
    @(negedge clk);
    put(32'h100, 32'hDEADBEEF, SEL_WORD, 1'b1);
    #1;
    check("s1_n1_req", mem_req, 1'b0);
    check("s1_n1_empty", empty, 1'b0);
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check("s1_n2_req", mem_req, 1'b1);
    check("s1_addr", mem_addr, 32'h100);
    check("s1_be", mem_be, 4'hF);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("s1_empty", empty, 1'b1);
    check("s1_idle_req", mem_req, 1'b0);
    check("s1_idle_addr", mem_addr, 32'h0);

    // Byte stores in lanes 2 and 3, then a misaligned halfword that must be dropped.
    put(32'h202, 32'h00AB0000, SEL_BYTE, 1'b1);
    @(negedge clk); #1;
    check("s2_be_lane2", mem_be, 4'b0100);
    check("s2_addr", mem_addr, 32'h200);
    drain(10);
    put(32'h203, 32'hAB000000, SEL_BYTE, 1'b1);
    @(negedge clk); #1;
    check("s2_be_lane3", mem_be, model_be(SEL_BYTE, 2'd3));
    check("s2_addr3", mem_addr, 32'h200);
    drain(10);
    @(negedge clk);
    put(32'h201, 32'h0000CDEF, SEL_HALF, 1'b1);
    #1;
    check("s2_mis_pulse", misalign_err, 1'b1);
    check("s2_mis_empty", empty, 1'b1);
    @(negedge clk); #1;
    check("s2_mis_clear", misalign_err, 1'b0);
    check("s2_mis_noreq", mem_req, 1'b0);

    // Fill while the memory stalls, then free one slot with a 5th store waiting.
    for (int i = 0; i < 4; i++) put(32'h400 + 32'(4 * i), $urandom, SEL_WORD, 1'b1);
    #1;
    check("s3_full_rdy", st_ready, 1'b0);
    check("s3_head_hold", mem_addr, 32'h400);
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h410; st_wdata = 32'h5555AAAA; st_sel = SEL_WORD;
    mem_ack = 1'b1;
    #1;
    check("s3_ack_rdy", st_ready, 1'b0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("s3_after_rdy", st_ready, 1'b1);
    sb.push_back('{addr: 32'h410, wdata: 32'h5555AAAA, be: 4'hF});
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    check("s3_refull_rdy", st_ready, 1'b0);
    drain(30);

    // Load hazard against a buffered (and in-flight) store.
    put(32'h300, 32'h12345678, SEL_WORD, 1'b1);
    @(negedge clk);
    ld_addr = 32'h302;
    #1;
    check("s4_noval", ld_stall, 1'b0);
    ld_valid = 1'b1;
    #1;
    check("s4_hit", ld_stall, 1'b1);
    ld_addr = 32'h304;
    #1;
    check("s4_miss", ld_stall, 1'b0);
    ld_valid = 1'b0;
    drain(10);
    ld_valid = 1'b1; ld_addr = 32'h302;
    #1;
    check("s4_after", ld_stall, 1'b0);
    ld_valid = 1'b0;

    // Reset in the middle of a request with two entries pending.
    put(32'h500, 32'hA0A0A0A0, SEL_WORD, 1'b1);
    put(32'h504, 32'hB0B0B0B0, SEL_WORD, 1'b1);
    #1;
    check("s5_inreq", mem_req, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    #1;
    check("s5_req", mem_req, 1'b0);
    check("s5_empty", empty, 1'b1);
    check("s5_rdy", st_ready, 1'b1);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("s5_ack_req", mem_req, 1'b0);
    check("s5_ack_empty", empty, 1'b1);

    // Streaming stores with the memory always acking: writes must be back to back.
    mem_ack = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        s = 2'($urandom_range(0, 2));
        a = 32'h1000 + 32'($urandom_range(0, 63) * 4);
        if (s == SEL_HALF) a[1] = 1'($urandom_range(0, 1));
        if (s == SEL_BYTE) a[1:0] = 2'($urandom_range(0, 3));
        d = $urandom;
        st_valid = 1'b1; st_addr = a; st_wdata = d; st_sel = s;
        e = '{addr: {a[31:2], 2'b00}, wdata: d, be: model_be(s, a[1:0])};
        sb.push_back(e);
      end else begin
        st_valid = 1'b0;
      end
      #1;
      if (c < 8) check("s6_rdy", st_ready, 1'b1);
      if (c >= 2 && c <= 9) check("s6_b2b_req", mem_req, 1'b1);
      if (c == 10) check("s6_empty", empty, 1'b1);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    @(negedge clk);
    check("sb_left", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
